// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end with a small in-order instruction buffer.
// Issues one instruction-memory read at a time at the current PC and holds
// the PC (pc_stall) whenever no read is issued. Returned words are queued
// together with their fetch address and presented to decode from the head.
// A branch flushes the queue and discards any read that is still in flight.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned pc (pc[1:0] != 0) blocks fetch and sets a
//               sticky align_err flag, which clears only on reset.
//   undefined : no alignment checking, align_err is tied to 0.
//
// Parameters
//   DEPTH        number of buffer entries (power of two, 2..16)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous reset, active low
//   pc           byte fetch address from the program counter
//   branch       flush request (same cycle the PC loads the branch target)
//   pc_stall     1 = PC holds this cycle (no fetch issued)
//   imem_req     instruction-memory read strobe, one cycle per request
//   imem_addr    read address, equal to pc
//   imem_rdata   returned instruction word
//   imem_rvalid  imem_rdata valid
//   instr        head-of-queue instruction
//   instr_pc     fetch address of instr
//   instr_valid  queue non-empty
//   instr_ready  decode accepts instr this cycle
//   align_err    sticky misaligned-fetch flag
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  pc,
    input  logic        branch,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [8:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] instr,
    output logic [8:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        align_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [8:0]    req_pc_q, req_pc_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [8:0]    addr_q [DEPTH];
    logic [8:0]    addr_d [DEPTH];

    logic          align_ok_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          not_full_s;

`ifdef FETCH_ALIGN_CHECK_EN
    logic          align_err_q, align_err_d;
    logic          misalign_s;

    assign misalign_s = (pc[1:0] != 2'b00);
    assign align_ok_s = ~misalign_s;
    assign align_err  = align_err_q;

    // Sticky flag: set by a fetch attempt at a misaligned address.
    always_comb begin
        align_err_d = align_err_q;
        if ((state_q == IDLE) && misalign_s && !branch) begin
            align_err_d = 1'b1;
        end else begin
            align_err_d = align_err_q;
        end
    end

    // Misaligned-fetch flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end
`else
    assign align_ok_s = 1'b1;
    assign align_err  = 1'b0;
`endif

    assign not_full_s = (count_q < DEPTH_C);

    // Request issue is combinational; rst is included so the strobe is low
    // while reset is held even though the idle state would otherwise allow it.
    assign issue_s = rst && (state_q == IDLE) && !branch && not_full_s && align_ok_s;

    // A returned word is kept only for a live (non-discarded) request and
    // only when no branch is flushing the queue on the same edge.
    assign push_s = (state_q == WAIT) && imem_rvalid && !branch;
    assign pop_s  = (count_q != {CW{1'b0}}) && instr_ready && !branch;

    assign imem_req    = issue_s;
    assign pc_stall    = ~issue_s;
    assign imem_addr   = pc;
    assign instr_valid = (count_q != {CW{1'b0}});
    assign instr       = data_q[rd_ptr_q];
    assign instr_pc    = addr_q[rd_ptr_q];

    // Request-tracking state machine.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            IDLE: begin
                if (issue_s) begin
                    state_d  = WAIT;
                    req_pc_d = pc;
                end else begin
                    state_d  = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else if (branch) begin
                    state_d = DROP;
                end else begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Occupancy and pointer update; a branch wipes the queue outright.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (branch) begin
            count_d  = {CW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PONE_C;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PONE_C;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer storage write at the tail.
    always_comb begin
        data_d = data_q;
        addr_d = addr_q;
        if (push_s) begin
            data_d[wr_ptr_q] = imem_rdata;
            addr_d[wr_ptr_q] = req_pc_q;
        end else begin
            data_d = data_q;
            addr_d = addr_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= {CW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            req_pc_q <= 9'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Buffer storage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 32'd0;
                addr_q[i] <= 9'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                addr_q[i] <= addr_d[i];
            end
        end
    end

endmodule
